// File: rtl/mcif_read_ig_bpt_split_if.sv
// Valid/ready request channel carrying a packed payload.
// One instance per side: DMA request in, burst request out.
interface mcif_read_ig_bpt_split_if #(
  parameter int PD_W = 77
) ();
  logic            req_valid;
  logic            req_ready;
  logic [PD_W-1:0] req_pd;

  modport master (output req_valid, output req_pd, input  req_ready);
  modport slave  (input  req_valid, input  req_pd, output req_ready);
endinterface

// File: rtl/mcif_read_ig_bpt_split.sv
// Splits a DMA read request (32B atoms) into AXI bursts of up to 8 atoms
// that never cross a 256B boundary. MCIF_BPT_OUT_PIPE_EN adds an output skid register.
module mcif_read_ig_bpt_split (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rstn,
  mcif_read_ig_bpt_split_if.slave          dma2bpt,
  input  logic [3:0]                       tieoff_axid,
  mcif_read_ig_bpt_split_if.master         bpt2arb
);

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [13:0] remaining_q, remaining_d;
  logic        ftran_pend_q, ftran_pend_d;
  logic        req_ready_q, req_ready_d;

  logic [3:0]  room;
  logic [3:0]  atoms;
  logic [2:0]  len;
  logic        fsm_valid;
  logic        fsm_ready;
  logic        fsm_ltran;
  logic [74:0] fsm_pd;
  logic        accept;
  logic        burst_hs;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^dma2bpt.req_pd[4:0];

  // Burst shape is a pure function of the current registers, so pd is
  // naturally stable while the burst waits for ready.
  always_comb begin
    room      = 4'd8 - {1'b0, addr_q[7:5]};
    atoms     = (remaining_q < {10'd0, room}) ? remaining_q[3:0] : room;
    len       = atoms[2:0] - 3'd1;
    fsm_ltran = (remaining_q == {10'd0, atoms});
    fsm_valid = (state_q == SPLIT);
    fsm_pd    = {(len[0] == addr_q[5]), addr_q[5], fsm_ltran, ftran_pend_q,
                 tieoff_axid, len, addr_q};
  end

  assign accept   = dma2bpt.req_valid & req_ready_q;
  assign burst_hs = fsm_valid & fsm_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    ftran_pend_d = ftran_pend_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d       = {dma2bpt.req_pd[63:5], 5'd0};
          remaining_d  = {1'b0, dma2bpt.req_pd[76:64]} + 14'd1;
          ftran_pend_d = 1'b1;
          state_d      = SPLIT;
        end
      end
      SPLIT: begin
        if (burst_hs) begin
          addr_d       = addr_q + {55'd0, atoms, 5'd0};
          remaining_d  = remaining_q - {10'd0, atoms};
          ftran_pend_d = 1'b0;
          if (fsm_ltran) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: low during reset, high in every IDLE cycle, which
    // leaves one bubble after the last burst.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      ftran_pend_q <= 1'b0;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      ftran_pend_q <= ftran_pend_d;
      req_ready_q  <= req_ready_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    addr_q <= addr_d;
  end

  assign dma2bpt.req_ready = req_ready_q;

`ifdef MCIF_BPT_OUT_PIPE_EN
  logic        main_vld_q, main_vld_d;
  logic        skid_vld_q, skid_vld_d;
  logic [74:0] main_pd_q, main_pd_d;
  logic [74:0] skid_pd_q, skid_pd_d;

  // Ready toward the FSM depends only on skid occupancy, so it is a flop.
  assign fsm_ready = ~skid_vld_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_pd_d  = main_pd_q;
    skid_vld_d = skid_vld_q;
    skid_pd_d  = skid_pd_q;
    if (bpt2arb.req_ready || !main_vld_q) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_pd_d  = skid_pd_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = burst_hs;
        if (burst_hs) main_pd_d = fsm_pd;
      end
    end else if (burst_hs) begin
      skid_vld_d = 1'b1;
      skid_pd_d  = fsm_pd;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    main_pd_q <= main_pd_d;
    skid_pd_q <= skid_pd_d;
  end

  assign bpt2arb.req_valid = main_vld_q;
  assign bpt2arb.req_pd    = main_pd_q;
`else
  assign fsm_ready         = bpt2arb.req_ready;
  assign bpt2arb.req_valid = fsm_valid;
  assign bpt2arb.req_pd    = fsm_pd;
`endif

endmodule

// File: doc/mcif_read_ig_bpt_split.md
MCIF_READ_IG_BPT_SPLIT -- requirements
Module: mcif_read_ig_bpt_split

Interface
REQ-001 SHALL have port nvdla_core_clk  input  1  core clock.
REQ-002 SHALL have port nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port dma2bpt_req_valid  input  1  DMA read request valid.
REQ-004 SHALL have port dma2bpt_req_ready  output  1  request accepted when valid&ready.
REQ-005 SHALL have port dma2bpt_req_pd  input  77  [63:0] byte addr (32B-aligned, bits[4:0] ignored); [76:64] size = atoms-1 (32B atoms).
REQ-006 SHALL have port tieoff_axid  input  4  AXI ID stamped on every burst; quasi-static.
REQ-007 SHALL have port bpt2arb_req_valid  output  1  burst valid toward the arbiter skid pipe.
REQ-008 SHALL have port bpt2arb_req_ready  input  1  burst accepted when valid&ready.
REQ-009 SHALL have port bpt2arb_req_pd  output  75  [63:0] addr; [66:64] len = atoms-1; [70:67] axid; [71] ftran; [72] ltran; [73] odd (addr[5]); [74] even-end (len[0]==addr[5]).

Function
REQ-010 SHALL implement FSM IDLE/SPLIT; dma2bpt_req_ready = 1 only in IDLE and out of reset.
REQ-011 On accept in IDLE SHALL latch addr (bits[4:0] forced 0), remaining = size+1 atoms, ftran_pend = 1, and go to SPLIT.
REQ-012 In SPLIT each burst SHALL have atoms = min(remaining, 8 - addr[7:5]); no burst crosses a 256B boundary.
REQ-013 len SHALL be atoms-1; ftran = 1 only on first burst; ltran = 1 only on the burst that drives remaining to 0.
REQ-014 On burst handshake SHALL add atoms*32 to addr (64-bit, wrap at 2^64 without error), subtract atoms from remaining, clear ftran_pend.
REQ-015 SHALL return SPLIT->IDLE on handshake of the ltran burst; next request accepted no earlier than the following cycle (one bubble).
REQ-016 Burst pd and valid SHALL hold stable while valid & !ready; no burst dropped or duplicated.
REQ-017 Latency: first burst valid 1 cycle after input accept (no pipe); 1 burst/cycle when ready held high.
REQ-018 size max (8192 atoms) SHALL yield 1024 or 1025 bursts; remaining SHALL be 14 bits.
REQ-019 Single-burst request SHALL set ftran = ltran = 1.

Reset
REQ-020 Reset SHALL force FSM IDLE, dma2bpt_req_ready 0 while asserted, bpt2arb_req_valid 0, remaining 0, ftran_pend 0; addr and pd datapath flops need no reset.
REQ-021 Reset mid-SPLIT SHALL abandon the request; no burst emitted after deassertion until a new request is accepted.

Configuration
REQ-022 Macro MCIF_BPT_OUT_PIPE_EN defined: bpt2arb_req_* SHALL pass through a 2-entry valid/ready skid register; +1 cycle latency, full throughput, ready toward FSM registered.
REQ-023 Macro undefined: bpt2arb_req_* SHALL be driven directly from FSM state registers per REQ-017.

Verification
REQ-024 addr 0x1000, size 7, ready=1 -> one burst: addr 0x1000, len 7, ftran=ltran=1, odd 0, even-end 0.
REQ-025 addr 0x10E0, size 9 -> bursts (0x10E0,len0,ftran), (0x1100,len7), (0x1200,len0,ltran); odd=1 on first only.
REQ-026 addr 0x1000, size 23, ready toggling 1,0,1,0 -> 3 bursts 0x1000/0x1100/0x1200 len 7, pd stable during stalls.
REQ-027 Back-to-back requests, input valid held -> ready low in SPLIT, exactly one idle cycle between ltran handshake and next accept.
REQ-028 Reset asserted after 1st of 3 bursts -> valid 0 immediately; after release no bursts until new request.
REQ-029 Repeat REQ-024..026 with MCIF_BPT_OUT_PIPE_EN -> identical burst sequence, latency +1 cycle.
